// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // Width of a counter that indexes bits 0..width-1 (never narrower than 1).
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder datapath cell: sum and carry-out of a + b + c.
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic c
);

   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: walks one full_adder cell across two WIDTH-bit operands,
// LSB first, one bit per clock, with a start/done handshake.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic            carry;
   logic            fa_sum, fa_cout;
   logic            accept, last_bit;

   // Ripple increment built from XOR/AND so the adder cell stays the only arithmetic.
   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          c;
      c = 1'b1;
      for (int i = 0; i < CW; i++) begin
         r[i] = v[i] ^ c;
         c    = v[i] & c;
      end
      return r;
   endfunction

   full_adder u_fa (
      .sum  (fa_sum),
      .cout (fa_cout),
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .c    (carry)
   );

   assign accept   = ((state == IDLE) || (state == DONE)) && start;
   assign last_bit = (cnt == LAST);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: DONE lasts one cycle and can re-accept immediately.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand/result shifting, carry flop, bit counter and held output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         carry  <= cin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
         carry  <= fa_cout;
         cnt    <= cnt_inc(cnt);
         // The final bit lands straight in the output register on the edge into DONE.
         if (last_bit) begin
            sum  <= {fa_sum, res_sh[WIDTH-1:1]};
            cout <= fa_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=2 instance
// checked every cycle against a transaction-level model, plus directed literals.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start2 = 1'b0, cin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, cout2;
   logic [1:0] sum2;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state per instance: remaining busy cycles, pending and held results.
   int         mcnt [2];
   logic       mdone[2];
   logic [8:0] mpend[2];
   logic [8:0] mres [2];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted op keeps the block busy for w cycles, then the exact
   // sum a+b+cin appears with a one-cycle done; a new op is accepted only when not busy.
   task automatic mstep(input int i, input logic s, input logic [7:0] av,
                        input logic [7:0] bv, input logic c, input int w);
      logic [8:0] full;
      full = {1'b0, av} + {1'b0, bv} + {8'd0, c};
      if (!rst_n) begin
         mcnt[i]  = 0;
         mdone[i] = 1'b0;
         mres[i]  = '0;
      end else begin
         mdone[i] = 1'b0;
         if (mcnt[i] > 0) begin
            mcnt[i]--;
            if (mcnt[i] == 0) begin
               mdone[i] = 1'b1;
               mres[i]  = mpend[i];
            end
         end else if (s) begin
            mpend[i] = full;
            mcnt[i]  = w;
         end
      end
   endtask

   always @(posedge clk) begin
      mstep(0, start8, a8, b8, cin8, 8);
      mstep(1, start2, {6'd0, a2}, {6'd0, b2}, cin2, 2);
   end

   // Per-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("w8 busy", {31'd0, busy8}, {31'd0, (mcnt[0] > 0)});
         chk("w8 done", {31'd0, done8}, {31'd0, mdone[0]});
         chk("w8 sum/cout", {23'd0, cout8, sum8}, {23'd0, mres[0]});
         chk("w2 busy", {31'd0, busy2}, {31'd0, (mcnt[1] > 0)});
         chk("w2 done", {31'd0, done2}, {31'd0, mdone[1]});
         chk("w2 sum/cout", {29'd0, cout2, sum2}, {29'd0, mres[1][2:0]});
      end
   end

   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic c,
                      input logic [8:0] exp, input string nm);
      int lat;
      @(negedge clk);
      a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = ~av; b8 = 8'($urandom); cin8 = ~c;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " done seen"}, {31'd0, done8}, 32'd1);
      chk({nm, " latency"}, lat, 32'd8);
      chk({nm, " result"}, {23'd0, cout8, sum8}, {23'd0, exp});
      chk({nm, " model"}, {23'd0, mres[0]}, {23'd0, exp});
   endtask

   task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic c,
                      input logic [2:0] exp, input string nm);
      int lat;
      @(negedge clk);
      a2 = av; b2 = bv; cin2 = c; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; a2 = ~av; b2 = ~bv; cin2 = ~c;
      lat = 0;
      while (!done2 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " done seen"}, {31'd0, done2}, 32'd1);
      chk({nm, " latency"}, lat, 32'd2);
      chk({nm, " result"}, {29'd0, cout2, sum2}, {29'd0, exp});
   endtask

   task automatic count_done8(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done8) n++;
      end
   endtask

   logic [7:0] b2b_a [4] = '{8'h01, 8'h80, 8'h7F, 8'hAA};
   logic [7:0] b2b_b [4] = '{8'h02, 8'h80, 8'h01, 8'h55};
   logic       b2b_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [8:0] b2b_e [4] = '{9'h003, 9'h101, 9'h080, 9'h100};

   initial begin
      int n, cyc;
      logic [7:0] ra, rb;
      logic [1:0] qa, qb;
      logic       rc;

      // Reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", {31'd0, busy8}, 32'd0);
      chk("reset done", {31'd0, done8}, 32'd0);
      chk("reset sum/cout", {23'd0, cout8, sum8}, 32'd0);
      rst_n = 1'b1;

      // Directed WIDTH=8 additions
      op8(8'h5A, 8'h3C, 1'b0, 9'h096, "5A+3C");
      op8(8'hFF, 8'h01, 1'b0, 9'h100, "FF+01");
      op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "FF+FF+1");

      // Start during RUN is ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("ignored start done", {31'd0, done8}, 32'd1);
      chk("ignored start result", {23'd0, cout8, sum8}, 32'h030);
      count_done8(15, n);
      chk("ignored start no 2nd done", n, 32'd0);

      // Back-to-back with start held high
      @(negedge clk);
      a8 = b2b_a[0]; b8 = b2b_b[0]; cin8 = b2b_c[0]; start8 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            chk("b2b no idle", {31'd0, (busy8 | done8)}, 32'd1);
            cyc++;
         end while (!done8 && cyc < 30);
         chk("b2b result", {23'd0, cout8, sum8}, {23'd0, b2b_e[k]});
         if (k < 3) begin
            a8 = b2b_a[k+1]; b8 = b2b_b[k+1]; cin8 = b2b_c[k+1];
         end else begin
            start8 = 1'b0;
         end
      end

      // Reset mid-RUN discards the operation
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort busy", {31'd0, busy8}, 32'd0);
      chk("abort sum/cout", {23'd0, cout8, sum8}, 32'd0);
      count_done8(12, n);
      chk("abort no done", n, 32'd0);
      op8(8'h01, 8'h01, 1'b0, 9'h002, "01+01 after abort");

      // Directed WIDTH=2 additions
      op2(2'd3, 2'd3, 1'b1, 3'd7, "w2 3+3+1");
      op2(2'd2, 2'd1, 1'b0, 3'd3, "w2 2+1");

      // Random sweeps
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, "w8 rand");
      end
      for (int k = 0; k < 1000; k++) begin
         qa = 2'($urandom); qb = 2'($urandom); rc = 1'($urandom);
         op2(qa, qb, rc, {1'b0, qa} + {1'b0, qb} + {2'd0, rc}, "w2 rand");
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
